// File: rtl/sd_pkg.sv
// Shared constants for the SD CMD-line response receiver.
// Feature macro SD_RESP_LONG_EN selects the 136-bit R2 path.
package sd_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_RECV       = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    localparam int LEN_SHORT   = 48;
    localparam int LEN_LONG    = 136;
    localparam int CRC_S_LO    = 0;
    localparam int CRC_S_HI    = 39;
    localparam int CRC_L_LO    = 8;
    localparam int CRC_L_HI    = 127;

    localparam logic [6:0] CRC7_POLY = 7'h09;

`ifdef SD_RESP_LONG_EN
    localparam int SR_W = LEN_LONG;
`else
    localparam int SR_W = LEN_SHORT;
`endif

endpackage

// File: rtl/crc7_chk.sv
// Serial CRC7 (x^7+x^3+1), MSB-first, zero initial value.
module crc7_chk
    import sd_pkg::*;
(
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       iclr,
    input  logic       ien,
    input  logic       idin,
    output logic [6:0] ocrc
);

    logic fb;

    assign fb = idin ^ ocrc[6];

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ocrc <= '0;
        end else if (iclr) begin
            ocrc <= '0;
        end else if (ien) begin
            ocrc <= {ocrc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_resp_rx.sv
// SD command response receiver: start-bit hunt, framing, CRC7 check.
// Define SD_RESP_LONG_EN to add 136-bit R2 reception and oresp_long.
module sd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX = 64
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         istart,
    input  logic         ilong,
    input  logic         inocrc,
    input  logic         icmd,
    output logic         obusy,
    output logic         odone,
    output logic         otimeout,
    output logic         ocrc_err,
    output logic         oframe_err,
    output logic [5:0]   oindex,
    output logic [31:0]  oarg
`ifdef SD_RESP_LONG_EN
    ,
    output logic [119:0] oresp_long
`endif
);

    localparam int TW = $clog2(NCR_MAX + 1);

    state_t          state, state_nxt;
    logic            long_q, nocrc_q, long_sel;
    logic [7:0]      bit_cnt, idx, last_idx;
    logic [TW-1:0]   tmo_cnt;
    logic [SR_W-2:0] sr;
    logic [SR_W-1:0] sr_nxt;
    logic            start_ok, tmo_hit, last_bit, rx_bit, crc_en;
    logic [6:0]      crc;
    logic            unused_sr;

`ifdef SD_RESP_LONG_EN
    assign long_sel = ilong;
`else
    logic unused_ilong;
    assign long_sel     = 1'b0;
    assign unused_ilong = ilong;
`endif

    assign start_ok  = (state == S_IDLE) && istart;
    assign tmo_hit   = (state == S_WAIT_START) && icmd
                     && (tmo_cnt == TW'(NCR_MAX - 1));
    assign last_idx  = long_q ? 8'(LEN_LONG - 1) : 8'(LEN_SHORT - 1);
    assign last_bit  = (state == S_RECV) && (bit_cnt == last_idx);
    assign sr_nxt    = {sr, icmd};
    assign unused_sr = ^sr_nxt;
    assign obusy     = (state != S_IDLE);
    assign odone     = (state == S_DONE);

    // The start bit is stream bit 0 and is sampled while still hunting.
    assign rx_bit = (state == S_RECV) || ((state == S_WAIT_START) && !icmd);
    assign idx    = (state == S_RECV) ? bit_cnt : 8'd0;
    assign crc_en = rx_bit && (long_q
                  ? (idx >= 8'(CRC_L_LO) && idx <= 8'(CRC_L_HI))
                  : (idx <= 8'(CRC_S_HI)));

    crc7_chk u_crc (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iclr   (start_ok),
        .ien    (crc_en),
        .idin   (icmd),
        .ocrc   (crc)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:       if (istart) state_nxt = S_WAIT_START;
            S_WAIT_START: begin
                if (!icmd)        state_nxt = S_RECV;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            S_RECV:       if (last_bit) state_nxt = S_DONE;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            long_q     <= 1'b0;
            nocrc_q    <= 1'b0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            sr         <= '0;
            otimeout   <= 1'b0;
            ocrc_err   <= 1'b0;
            oframe_err <= 1'b0;
            oindex     <= '0;
            oarg       <= '0;
`ifdef SD_RESP_LONG_EN
            oresp_long <= '0;
`endif
        end else begin
            otimeout <= tmo_hit;
            if (start_ok) begin
                long_q     <= long_sel;
                nocrc_q    <= inocrc;
                bit_cnt    <= '0;
                tmo_cnt    <= '0;
                ocrc_err   <= 1'b0;
                oframe_err <= 1'b0;
            end
            if (state == S_WAIT_START) begin
                if (!icmd) begin
                    bit_cnt <= 8'd1;
                    sr      <= sr_nxt[SR_W-2:0];
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
            if (state == S_RECV) begin
                sr      <= sr_nxt[SR_W-2:0];
                bit_cnt <= bit_cnt + 8'd1;
                if (bit_cnt == 8'd1 && icmd) oframe_err <= 1'b1;
                if (last_bit) begin
                    if (!icmd) oframe_err <= 1'b1;
                    ocrc_err <= !nocrc_q && (sr_nxt[7:1] != crc);
                    if (!long_q) begin
                        oindex <= sr_nxt[45:40];
                        oarg   <= sr_nxt[39:8];
                    end
`ifdef SD_RESP_LONG_EN
                    else begin
                        oresp_long <= sr_nxt[127:8];
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_resp_rx.sv
// Scoreboard bench for sd_resp_rx with a polynomial-division CRC model.
// Exercises the R2 path too when SD_RESP_LONG_EN is defined.
module tb_sd_resp_rx;
    import sd_pkg::*;

    localparam int NCR = 64;

    logic         iclk = 1'b0;
    logic         irst_n = 1'b0;
    logic         istart = 1'b0;
    logic         ilong = 1'b0;
    logic         inocrc = 1'b0;
    logic         icmd = 1'b1;
    logic         obusy, odone, otimeout, ocrc_err, oframe_err;
    logic [5:0]   oindex;
    logic [31:0]  oarg;
`ifdef SD_RESP_LONG_EN
    logic [119:0] oresp_long;
`endif

    always #5 iclk = ~iclk;

    sd_resp_rx #(.NCR_MAX(NCR)) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .istart     (istart),
        .ilong      (ilong),
        .inocrc     (inocrc),
        .icmd       (icmd),
        .obusy      (obusy),
        .odone      (odone),
        .otimeout   (otimeout),
        .ocrc_err   (ocrc_err),
        .oframe_err (oframe_err),
        .oindex     (oindex),
        .oarg       (oarg)
`ifdef SD_RESP_LONG_EN
        ,
        .oresp_long (oresp_long)
`endif
    );

    typedef struct {
        bit           to;
        bit           lng;
        bit           crc_err;
        bit           frame_err;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [119:0] rl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^7 divided by x^7+x^3+1, first bit = v[n-1].
    function automatic logic [6:0] crc7_ref(input logic [135:0] v,
                                            input int n);
        logic [6:0] r;
        bit top, b;
        r = '0;
        for (int i = 0; i < n + 7; i++) begin
            b   = (i < n) ? v[n-1-i] : 1'b0;
            top = r[6];
            r   = {r[5:0], b};
            if (top) r = r ^ 7'h09;
        end
        return r;
    endfunction

    always @(negedge iclk) begin
        if (irst_n && (odone || otimeout)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got done=%0b timeout=%0b expected none",
                         odone, otimeout);
            end else begin
                mon_e = sb.pop_front();
                chk("kind", {odone, otimeout}, mon_e.to ? 2'b01 : 2'b10);
                if (!mon_e.to) begin
                    chk("crc_err", ocrc_err, mon_e.crc_err);
                    chk("frame_err", oframe_err, mon_e.frame_err);
                    if (!mon_e.lng) begin
                        chk("index", oindex, mon_e.idx);
                        chk("arg", oarg, mon_e.arg);
                    end
`ifdef SD_RESP_LONG_EN
                    else chk("resp_long", oresp_long, mon_e.rl);
`endif
                end
            end
        end
    end

    task automatic arm(input bit lng, input bit nocrc);
        @(negedge iclk);
        istart = 1'b1;
        ilong  = lng;
        inocrc = nocrc;
        icmd   = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
    endtask

    task automatic drive_bits(input logic [135:0] v, input int len,
                              input int first, input int last,
                              input bit poke);
        for (int i = first; i <= last; i++) begin
            icmd = v[len-1-i];
            istart = poke && (i == 10);
            ilong  = poke && (i == 10);
            inocrc = poke && (i == 10);
            @(negedge iclk);
        end
        istart = 1'b0;
        icmd   = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!obusy) return;
            @(negedge iclk);
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: got busy after 400 cycles expected idle");
    endtask

    task automatic run_raw(input logic [135:0] fr, input int len,
                           input bit lng, input bit nocrc, input int idle,
                           input bit poke, input exp_t e);
        sb.push_back(e);
        arm(lng, nocrc);
        repeat (idle) @(negedge iclk);
        drive_bits(fr, len, 0, len - 1, poke);
        wait_idle();
        repeat (3) @(negedge iclk);
        chk("hold_crc_err", ocrc_err, e.crc_err);
        chk("hold_frame_err", oframe_err, e.frame_err);
        if (!lng) chk("hold_index", oindex, e.idx);
    endtask

    task automatic run_short(input logic [5:0] idx, input logic [31:0] arg,
                             input bit tx, input bit flip, input bit endb,
                             input bit nocrc, input int idle, input bit poke);
        logic [39:0] c;
        logic [6:0]  crc;
        exp_t        e;
        c   = {1'b0, tx, idx, arg};
        crc = crc7_ref({96'h0, c}, 40) ^ {6'h0, flip};
        e   = '{to: 0, lng: 0, crc_err: flip && !nocrc,
                frame_err: tx || !endb, idx: idx, arg: arg, rl: '0};
        run_raw({88'h0, c, crc, endb}, 48, 1'b0, nocrc, idle, poke, e);
    endtask

    task automatic run_long(input logic [119:0] content, input bit flip,
                            input int idle);
        logic [6:0] crc;
        exp_t       e;
        crc = crc7_ref({16'h0, content}, 120) ^ {6'h0, flip};
        e   = '{to: 0, lng: 1, crc_err: flip, frame_err: 0,
                idx: '0, arg: '0, rl: content};
        run_raw({2'b00, 6'h3F, content, crc, 1'b1}, 136, 1'b1, 1'b0,
                idle, 1'b0, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [135:0] fr;
        int got;
        repeat (3) @(negedge iclk);
        chk("rst_busy", obusy, 1'b0);
        chk("rst_done", odone, 1'b0);
        chk("rst_timeout", otimeout, 1'b0);
        chk("rst_index", oindex, 6'd0);
        chk("rst_arg", oarg, 32'd0);
        irst_n = 1'b1;
        @(negedge iclk);

        e = '{to: 0, lng: 0, crc_err: 0, frame_err: 0,
              idx: 6'd17, arg: 32'h900, rl: '0};
        run_raw(136'h110000090067, 48, 0, 0, 3, 0, e);

        e.crc_err = 1;
        run_raw(136'h110000090065, 48, 0, 0, 3, 0, e);
        e.crc_err = 0;
        run_raw(136'h110000090065, 48, 0, 1, 3, 0, e);

        e.frame_err = 1;
        run_raw(136'h110000090066, 48, 0, 0, 2, 0, e);

        e = '{to: 1, lng: 0, crc_err: 0, frame_err: 0,
              idx: '0, arg: '0, rl: '0};
        sb.push_back(e);
        arm(0, 0);
        chk("busy_wait", obusy, 1'b1);
        got = 0;
        for (int i = 1; i <= NCR + 4; i++) begin
            @(negedge iclk);
            if (otimeout && got == 0) got = i;
        end
        chk("timeout_latency", got, NCR);
        chk("timeout_busy", obusy, 1'b0);

        e = '{to: 0, lng: 0, crc_err: 0, frame_err: 0,
              idx: 6'd17, arg: 32'h900, rl: '0};
        run_raw(136'h110000090067, 48, 0, 0, 1, 0, e);
        fr = 136'h1A0123456789;
        arm(0, 0);
        drive_bits(fr, 48, 0, 19, 0);
        irst_n = 1'b0;
        #1;
        chk("mid_rst_busy", obusy, 1'b0);
        chk("mid_rst_index", oindex, 6'd0);
        chk("mid_rst_arg", oarg, 32'd0);
        chk("mid_rst_status", {ocrc_err, oframe_err, odone}, 3'b000);
        repeat (2) @(negedge iclk);
        irst_n = 1'b1;
        drive_bits(fr, 48, 20, 47, 0);
        chk("post_rst_idle", obusy, 1'b0);
        run_raw(136'h110000090067, 48, 0, 0, 0, 0, e);

        for (int n = 0; n < 24; n++) begin
            run_short(6'($urandom), $urandom, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 8),
                      $urandom_range(0, 3) == 0);
        end

`ifdef SD_RESP_LONG_EN
        run_long({15{8'hA5}}, 0, 2);
        for (int n = 0; n < 6; n++) begin
            run_long({$urandom, $urandom, $urandom, 24'($urandom)},
                     $urandom_range(0, 2) == 0, $urandom_range(0, 5));
        end
`endif

        repeat (4) @(negedge iclk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_resp_rx.md
SD_RESP_RX -- requirements
Module: sd_resp_rx

Interface
REQ-001 SHALL have parameter NCR_MAX, default 64, max clocks from istart to response start bit before timeout.
REQ-002 SHALL have parameter (none other); widths are fixed.
REQ-003 SHALL have port iclk  in  1  SD clock; CMD line sampled on rising edge.
REQ-004 SHALL have port irst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port istart  in  1  one-cycle pulse arming reception.
REQ-006 SHALL have port ilong  in  1  sampled with istart; 1 = 136-bit R2 response.
REQ-007 SHALL have port inocrc  in  1  sampled with istart; 1 = skip CRC check (R3).
REQ-008 SHALL have port icmd  in  1  serial CMD line, idle high.
REQ-009 SHALL have port obusy  out  1  high from istart until odone/otimeout.
REQ-010 SHALL have port odone  out  1  one-cycle pulse, response complete.
REQ-011 SHALL have port otimeout  out  1  one-cycle pulse, no start bit within NCR_MAX.
REQ-012 SHALL have ports ocrc_err, oframe_err  out  1  each; status, valid from odone until next istart.
REQ-013 SHALL have ports oindex  out  6, oarg  out  32  short-response fields.
REQ-014 SHALL have port oresp_long  out  120  R2 content bits (present only per REQ-031).

Function
REQ-015 SHALL implement states IDLE, WAIT_START, RECV, DONE.
REQ-016 SHALL, in IDLE on istart, latch ilong/inocrc, clear status and CRC, clear timeout counter, enter WAIT_START.
REQ-017 SHALL ignore istart when not in IDLE.
REQ-018 SHALL, in WAIT_START, enter RECV on first sampled icmd=0 (stream bit 0) with bit counter=1.
REQ-019 SHALL, in WAIT_START, pulse otimeout and return to IDLE when the counter reaches NCR_MAX with no start bit; odone not asserted.
REQ-020 SHALL sample one bit per iclk in RECV, MSB first; length 48 (short) or 136 (long).
REQ-021 SHALL set oframe_err if transmission bit (bit 1) is not 0 or end bit (last bit) is not 1.
REQ-022 SHALL compute CRC7 (x^7+x^3+1, init 0) over bits 0..39 for short, bits 8..127 for long.
REQ-023 SHALL compare next 7 received bits to computed CRC; mismatch sets ocrc_err unless inocrc latched (then ocrc_err=0).
REQ-024 SHALL load oindex from bits 2..7, oarg from bits 8..39, oresp_long from bits 8..127.
REQ-025 SHALL enter DONE the cycle after the end bit is sampled; odone asserted in DONE for exactly one cycle; then IDLE.
REQ-026 SHALL keep obusy high in WAIT_START, RECV, DONE; low in IDLE.
REQ-027 SHALL hold data and status outputs stable after odone until the next accepted istart.

Reset
REQ-028 SHALL, on irst_n low at any time incl. mid-reception, force IDLE; all outputs 0, counters and CRC 0.
REQ-029 SHALL, after release, require a fresh istart; a partial frame is discarded.

Configuration
REQ-030 SHALL use macro SD_RESP_LONG_EN.
REQ-031 SHALL, with SD_RESP_LONG_EN defined, support R2 per REQ-020..024 with oresp_long present; without it, omit oresp_long, ignore ilong (always 48 bits).

Structure
REQ-032 SHALL place state encoding, lengths 48/136, CRC ranges, and CRC7 polynomial constant in shared package sd_pkg.
REQ-033 SHALL use one sub-module crc7_chk: serial CRC7 with clear, enable, data in, 7-bit parallel out.

Verification
REQ-034 SHALL test R1: istart, ilong=0, 3 idle-high clocks, stream 0x110000090067 (CMD17, arg 0x00000900, CRC 0x33) -> odone, oindex=17, oarg=0x00000900, ocrc_err=0, oframe_err=0.
REQ-035 SHALL test CRC error: same stream with CRC bits 0x32 -> odone, ocrc_err=1; repeat with inocrc=1 -> ocrc_err=0.
REQ-036 SHALL test timeout: istart, icmd held 1 -> otimeout at NCR_MAX clocks, no odone, obusy low after.
REQ-037 SHALL test frame error: valid R1 with end bit 0 -> oframe_err=1, ocrc_err=0.
REQ-038 SHALL test reset mid-RECV (irst_n low at bit 20) -> outputs 0, IDLE; next valid R1 received correctly.
REQ-039 SHALL test (SD_RESP_LONG_EN) R2 with 120 content bits 0xA5 repeated and correct CRC -> oresp_long matches, ocrc_err=0.
